// File: rtl/acc_control.sv
// Multi-cycle accumulator-machine controller: a registered state sequencer with
// all selects and strobes decoded from the state register, opcode and handshakes.
module acc_control (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic [2:0] SrcA,
  output logic [3:0] SrcB,
  output logic [2:0] ALUOP,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       ACCWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       Halted,
  output logic [2:0] State
);

  // State encodings (visible on State for debug).
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEMRD  = 3'd3;
  localparam logic [2:0] S_MEMWR  = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] A_PC  = 3'd0;
  localparam logic [2:0] A_ACC = 3'd1;

  localparam logic [3:0] B_TWO = 4'd0;
  localparam logic [3:0] B_SE  = 4'd1;
  localparam logic [3:0] B_MDR = 4'd2;
  localparam logic [3:0] B_ZE  = 4'd3;
  localparam logic [3:0] B_SL1 = 4'd4;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_PASSA = 3'd4;
  localparam logic [2:0] ALU_PASSB = 3'd5;

  logic [2:0] state_q, state_d;

  // Ungated decode of the current state; forced to zero below while in reset.
  logic [2:0] srca_c;
  logic [3:0] srcb_c;
  logic [2:0] aluop_c;
  logic       pcwrite_c, pcsrc_c, irwrite_c, mdrwrite_c, accwrite_c;
  logic       memread_c, memwrite_c, iord_c, halted_c;

  // NOTE: non-blocking assignment keeps every register update race-free
  // relative to other clocked blocks sampling state_q on the same edge.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (Opcode)
          OP_HALT:                         state_d = S_HALT;
          OP_LD, OP_ADD, OP_SUB,
          OP_AND, OP_OR:                   state_d = S_MEMRD;
          OP_ST:                           state_d = S_MEMWR;
          OP_LDI, OP_ADDI, OP_BEQZ, OP_JMP: state_d = S_EXEC;
          default:                         state_d = S_FETCH;
        endcase
      end
      S_EXEC:   state_d = S_FETCH;
      S_MEMRD:  state_d = mem_ready ? S_WB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    srca_c     = A_PC;
    srcb_c     = B_TWO;
    aluop_c    = ALU_ADD;
    pcwrite_c  = 1'b0;
    pcsrc_c    = 1'b0;
    irwrite_c  = 1'b0;
    mdrwrite_c = 1'b0;
    accwrite_c = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    iord_c     = 1'b0;
    halted_c   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        memread_c = 1'b1;
        irwrite_c = mem_ready;
        pcwrite_c = mem_ready;
      end
      S_DECODE: srcb_c = B_SL1;  // branch target precomputed into aluOut
      S_EXEC: begin
        unique case (Opcode)
          OP_LDI: begin
            srcb_c     = B_ZE;
            aluop_c    = ALU_PASSB;
            accwrite_c = 1'b1;
          end
          OP_ADDI: begin
            srca_c     = A_ACC;
            srcb_c     = B_SE;
            accwrite_c = 1'b1;
          end
          OP_BEQZ: begin
            srca_c    = A_ACC;
            aluop_c   = ALU_PASSA;
            pcsrc_c   = 1'b1;
            pcwrite_c = Zero;
          end
          OP_JMP: begin
            pcsrc_c   = 1'b1;
            pcwrite_c = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEMRD: begin
        memread_c  = 1'b1;
        iord_c     = 1'b1;
        mdrwrite_c = mem_ready;
      end
      S_MEMWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
      end
      S_WB: begin
        srca_c     = A_ACC;
        srcb_c     = B_MDR;
        accwrite_c = 1'b1;
        unique case (Opcode)
          OP_LD:   aluop_c = ALU_PASSB;
          OP_SUB:  aluop_c = ALU_SUB;
          OP_AND:  aluop_c = ALU_AND;
          OP_OR:   aluop_c = ALU_OR;
          default: aluop_c = ALU_ADD;
        endcase
      end
      S_HALT:  halted_c = 1'b1;
      default: ;
    endcase
  end

  // NOTE: FETCH decodes to MemRead=1, so the outputs are gated with reset_n to
  // drop every strobe the instant reset asserts, aborting any memory access.
  always_comb begin
    SrcA     = reset_n ? srca_c     : 3'd0;
    SrcB     = reset_n ? srcb_c     : 4'd0;
    ALUOP    = reset_n ? aluop_c    : 3'd0;
    PCWrite  = reset_n & pcwrite_c;
    PCSrc    = reset_n & pcsrc_c;
    IRWrite  = reset_n & irwrite_c;
    MDRWrite = reset_n & mdrwrite_c;
    ACCWrite = reset_n & accwrite_c;
    MemRead  = reset_n & memread_c;
    MemWrite = reset_n & memwrite_c;
    IorD     = reset_n & iord_c;
    Halted   = reset_n & halted_c;
    State    = state_q;
  end

  a_mem_excl: assert property (@(posedge CLK) disable iff (!reset_n)
    !(MemRead && MemWrite));

  a_halt_sticky: assert property (@(posedge CLK) disable iff (!reset_n)
    (state_q == S_HALT) |=> (state_q == S_HALT));

  a_illegal_recovers: assert property (@(posedge CLK) disable iff (!reset_n)
    (state_q == 3'd7) |=> (state_q == S_FETCH));

endmodule
